// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Definitions shared by the digital-clock blocks: mode codes from the mode
// selector, field_sel codes, the setting-controller state encoding, the
// edit target, and the wrap limits for the time fields.
// ---------------------------------------------------------------------------
package clock_pkg;

   // Mode selector codes
   localparam logic [1:0] MODE_CLOCK     = 2'b00;
   localparam logic [1:0] MODE_ALARM     = 2'b01;
   localparam logic [1:0] MODE_STOPWATCH = 2'b10;
   localparam logic [1:0] MODE_SET       = 2'b11;

   // field_sel codes
   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   // Field wrap limits (seconds share the minute limit)
   localparam logic [4:0] HOUR_MAX = 5'd23;
   localparam logic [5:0] MIN_MAX  = 6'd59;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EDIT_H,
      ST_EDIT_M,
      ST_EDIT_S,
      ST_COMMIT
   } state_t;

   // Which register the editing session will load on commit
   typedef enum logic {
      TGT_TIME,
      TGT_ALARM
   } target_t;

endpackage

// File: rtl/tick_div.sv
// ---------------------------------------------------------------------------
// tick_div
// Cycle counter with a restart input and a terminal-count pulse.
// Counts 0..PERIOD-1 while en is high; tc pulses for one cycle on the count
// of PERIOD-1 and the counter wraps to 0. restart or a low en clears it.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   count enable
//   restart  in   synchronous clear; suppresses tc in the same cycle
//   tc       out  terminal-count pulse
// ---------------------------------------------------------------------------
module tick_div #(
   parameter int PERIOD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic restart,
   output logic tc
);

   localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [W-1:0] LAST = W'(PERIOD - 1);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (restart || !en || (cnt == LAST))
         cnt <= '0;
      else
         cnt <= cnt + W'(1);
   end

   assign tc = en && !restart && (cnt == LAST);

endmodule

// File: rtl/set_ctrl.sv
// ---------------------------------------------------------------------------
// set_ctrl
// Setting-mode controller of the digital clock. In set-time and alarm modes
// it captures the current time or alarm, lets the user step through fields
// and increment them with wrap, and on confirm pulses a one-cycle load strobe
// to the time-of-day counter or the alarm register. Sessions are abandoned on
// a mode change or after TIMEOUT_S seconds without a key press.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   model[1:0]                       mode code from the mode selector
//   key_sel / key_inc / key_ok       debounced one-cycle key pulses
//   cur_hour/cur_min/cur_sec         running time
//   alm_hour/alm_min                 stored alarm
//   edit_hour/edit_min/edit_sec      value under edit
//   field_sel[1:0]                   0 none, 1 hour, 2 min, 3 sec
//   blink_on                         selected field visible
//   editing                          session active (EDIT_* or COMMIT)
//   time_load / alm_load             one-cycle load strobes
// ---------------------------------------------------------------------------
module set_ctrl
   import clock_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int TIMEOUT_S = 10,
   parameter int BLINK_HZ  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] model,
   input  logic       key_sel,
   input  logic       key_inc,
   input  logic       key_ok,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   input  logic [4:0] alm_hour,
   input  logic [5:0] alm_min,
   output logic [4:0] edit_hour,
   output logic [5:0] edit_min,
   output logic [5:0] edit_sec,
   output logic [1:0] field_sel,
   output logic       blink_on,
   output logic       editing,
   output logic       time_load,
   output logic       alm_load
);

   localparam int TIMEOUT_CYC = TIMEOUT_S * CLK_FREQ;
   localparam int BLINK_CYC   = CLK_FREQ / (2 * BLINK_HZ);

   state_t     state_q, state_d;
   target_t    target_q, target_d;
   logic [1:0] model_q;
   logic [4:0] hour_q, hour_d;
   logic [5:0] min_q, min_d;
   logic [5:0] sec_q, sec_d;
   logic       blink_q;

   logic any_key, mode_changed, edit_mode, in_edit, entry;
   logic timeout_tc, blink_tc;

   assign any_key      = key_sel || key_inc || key_ok;
   assign mode_changed = (model != model_q);
   assign edit_mode    = (model == MODE_SET) || (model == MODE_ALARM);
   assign in_edit      = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M) ||
                         (state_q == ST_EDIT_S);
   assign entry        = (state_q == ST_IDLE) && edit_mode &&
                         (mode_changed || key_sel);

   // Inactivity timeout: restarted by any key and by session entry.
   tick_div #(.PERIOD(TIMEOUT_CYC)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (in_edit),
      .restart (any_key || entry),
      .tc      (timeout_tc)
   );

   // Blink half-period divider: same restart rule so a key shows the field.
   tick_div #(.PERIOD(BLINK_CYC)) u_blink (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (in_edit),
      .restart (any_key || entry),
      .tc      (blink_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         target_q <= TGT_TIME;
         model_q  <= MODE_CLOCK;
         hour_q   <= '0;
         min_q    <= '0;
         sec_q    <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         model_q  <= model;
         hour_q   <= hour_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
      end
   end

   // Next-state and edit-value logic. Priority inside a session:
   // mode change (abandon) > key_ok > key_sel > key_inc > timeout.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; a missing default infers a latch.
      state_d  = state_q;
      target_d = target_q;
      hour_d   = hour_q;
      min_d    = min_q;
      sec_d    = sec_q;

      case (state_q)
         ST_IDLE: begin
            if (entry) begin
               state_d = ST_EDIT_H;
               if (model == MODE_SET) begin
                  target_d = TGT_TIME;
                  hour_d   = cur_hour;
                  min_d    = cur_min;
                  sec_d    = cur_sec;
               end else begin
                  target_d = TGT_ALARM;
                  hour_d   = alm_hour;
                  min_d    = alm_min;
                  sec_d    = '0;
               end
            end
         end

         ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
            if (mode_changed) begin
               state_d = ST_IDLE;
            end else if (key_ok) begin
               state_d = ST_COMMIT;
            end else if (key_sel) begin
               case (state_q)
                  ST_EDIT_H: state_d = ST_EDIT_M;
                  ST_EDIT_M: state_d = (target_q == TGT_TIME) ? ST_EDIT_S : ST_EDIT_H;
                  default:   state_d = ST_EDIT_H;
               endcase
            end else if (key_inc) begin
               case (state_q)
                  ST_EDIT_H: hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
                  ST_EDIT_M: min_d  = (min_q  == MIN_MAX)  ? '0 : min_q  + 6'd1;
                  default:   sec_d  = (sec_q  == MIN_MAX)  ? '0 : sec_q  + 6'd1;
               endcase
            end else if (timeout_tc) begin
               state_d = ST_IDLE;
            end
         end

         ST_COMMIT: state_d = ST_IDLE;

         default:   state_d = ST_IDLE;
      endcase
   end

   // Blink: dark whenever the session is (or is about to be) idle, lit by any
   // key or entry, otherwise toggled by the divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         blink_q <= 1'b0;
      else if (state_d == ST_IDLE)
         blink_q <= 1'b0;
      else if (any_key || entry)
         blink_q <= 1'b1;
      else if (blink_tc)
         blink_q <= !blink_q;
   end

   always_comb begin
      field_sel = FIELD_NONE;
      case (state_q)
         ST_EDIT_H: field_sel = FIELD_HOUR;
         ST_EDIT_M: field_sel = FIELD_MIN;
         ST_EDIT_S: field_sel = FIELD_SEC;
         default:   field_sel = FIELD_NONE;
      endcase
   end

   assign edit_hour = hour_q;
   assign edit_min  = min_q;
   assign edit_sec  = sec_q;
   assign blink_on  = blink_q;
   assign editing   = in_edit || (state_q == ST_COMMIT);
   assign time_load = (state_q == ST_COMMIT) && (target_q == TGT_TIME);
   assign alm_load  = (state_q == ST_COMMIT) && (target_q == TGT_ALARM);

endmodule

// File: tb/tb_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_set_ctrl
// Directed bench for set_ctrl with CLK_FREQ=1000, TIMEOUT_S=1, BLINK_HZ=2
// (timeout after 1000 idle cycles, blink toggle every 250 cycles).
// Expected load strobes are queued by the stimulus; a monitor pops and
// compares whenever time_load or alm_load is seen.
// ---------------------------------------------------------------------------
module tb_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] model;
   logic       key_sel, key_inc, key_ok;
   logic [4:0] cur_hour, alm_hour;
   logic [5:0] cur_min, cur_sec, alm_min;
   logic [4:0] edit_hour;
   logic [5:0] edit_min, edit_sec;
   logic [1:0] field_sel;
   logic       blink_on, editing, time_load, alm_load;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic       t_load;
      logic       a_load;
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
   } exp_t;

   exp_t sb[$];

   set_ctrl #(.CLK_FREQ(1000), .TIMEOUT_S(1), .BLINK_HZ(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .model     (model),
      .key_sel   (key_sel),
      .key_inc   (key_inc),
      .key_ok    (key_ok),
      .cur_hour  (cur_hour),
      .cur_min   (cur_min),
      .cur_sec   (cur_sec),
      .alm_hour  (alm_hour),
      .alm_min   (alm_min),
      .edit_hour (edit_hour),
      .edit_min  (edit_min),
      .edit_sec  (edit_sec),
      .field_sel (field_sel),
      .blink_on  (blink_on),
      .editing   (editing),
      .time_load (time_load),
      .alm_load  (alm_load)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one clock; outputs are then settled for checking.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One-cycle key pulse sampled by the next edge.
   task automatic press(input logic s, input logic i, input logic o);
      key_sel = s;
      key_inc = i;
      key_ok  = o;
      cyc();
      key_sel = 1'b0;
      key_inc = 1'b0;
      key_ok  = 1'b0;
   endtask

   task automatic expect_load(input logic t, input logic a, input logic [4:0] h,
                              input logic [5:0] m, input logic [5:0] s);
      exp_t e;
      e.t_load = t;
      e.a_load = a;
      e.h = h;
      e.m = m;
      e.s = s;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: every strobe cycle must match a queued expectation.
   always @(negedge clk) begin
      if (rst_n && (time_load || alm_load)) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe: time_load=%0b alm_load=%0b edit=%0d:%0d:%0d, expected no strobe",
                     time_load, alm_load, edit_hour, edit_min, edit_sec);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (time_load !== e.t_load || alm_load !== e.a_load ||
                edit_hour !== e.h || edit_min !== e.m || edit_sec !== e.s) begin
               fails++;
               $display("FAIL load_value: got t=%0b a=%0b %0d:%0d:%0d, expected t=%0b a=%0b %0d:%0d:%0d",
                        time_load, alm_load, edit_hour, edit_min, edit_sec,
                        e.t_load, e.a_load, e.h, e.m, e.s);
            end
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      model    = 2'b00;
      key_sel  = 1'b0;
      key_inc  = 1'b0;
      key_ok   = 1'b0;
      cur_hour = '0; cur_min = '0; cur_sec = '0;
      alm_hour = '0; alm_min = '0;
      repeat (3) cyc();

      // Reset state
      check("rst_editing",   editing,   0);
      check("rst_field_sel", field_sel, 0);
      check("rst_blink",     blink_on,  0);
      check("rst_edit_hour", edit_hour, 0);
      check("rst_loads",     {time_load, alm_load}, 0);
      rst_n = 1'b1;
      cyc();

      // Time set: enter with 12:34:56, 12 increments wrap hour to 0, commit
      cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
      model = 2'b11;
      cyc();
      check("ts_editing",   editing,   1);
      check("ts_field",     field_sel, 1);
      check("ts_capture",   {edit_hour, edit_min, edit_sec}, {5'd12, 6'd34, 6'd56});
      check("ts_blink",     blink_on,  1);
      repeat (12) press(1'b0, 1'b1, 1'b0);
      check("ts_hour_wrap", edit_hour, 0);
      expect_load(1'b1, 1'b0, 5'd0, 6'd34, 6'd56);
      press(1'b0, 1'b0, 1'b1);
      check("ts_commit_editing", editing,   1);
      check("ts_commit_field",   field_sel, 0);
      check("ts_commit_strobe",  time_load, 1);
      cyc();
      check("ts_after_editing", editing,   0);
      check("ts_after_strobe",  time_load, 0);
      check("ts_hold",          {edit_hour, edit_min, edit_sec}, {5'd0, 6'd34, 6'd56});

      // Wrap and isolation: re-enter via key_sel, min and sec wrap alone
      cur_hour = 5'd5; cur_min = 6'd59; cur_sec = 6'd59;
      press(1'b1, 1'b0, 1'b0);
      check("wr_capture", {edit_hour, edit_min, edit_sec}, {5'd5, 6'd59, 6'd59});
      press(1'b1, 1'b0, 1'b0);
      check("wr_field_min", field_sel, 2);
      press(1'b0, 1'b1, 1'b0);
      check("wr_min_wrap", {edit_hour, edit_min, edit_sec}, {5'd5, 6'd0, 6'd59});
      press(1'b1, 1'b0, 1'b0);
      check("wr_field_sec", field_sel, 3);
      press(1'b0, 1'b1, 1'b0);
      check("wr_sec_wrap", {edit_hour, edit_min, edit_sec}, {5'd5, 6'd0, 6'd0});
      press(1'b1, 1'b0, 1'b0);
      check("wr_field_back", field_sel, 1);
      model = 2'b00;   // abandon, no strobe expected
      cyc();
      check("wr_abandon", editing, 0);
      cyc();

      // Alarm: enter with 07:30, field toggles 1-2-1, hour+1, commit
      alm_hour = 5'd7; alm_min = 6'd30;
      model = 2'b01;
      cyc();
      check("al_capture", {edit_hour, edit_min, edit_sec}, {5'd7, 6'd30, 6'd0});
      press(1'b1, 1'b0, 1'b0);
      check("al_field_2", field_sel, 2);
      press(1'b1, 1'b0, 1'b0);
      check("al_field_1", field_sel, 1);
      press(1'b0, 1'b1, 1'b0);
      check("al_inc", edit_hour, 8);
      expect_load(1'b0, 1'b1, 5'd8, 6'd30, 6'd0);
      press(1'b0, 1'b0, 1'b1);
      check("al_strobe", {time_load, alm_load}, 2'b01);
      cyc();
      check("al_done", editing, 0);

      // Timeout: 1000 idle cycles after entry; blink toggles after 250
      press(1'b1, 1'b0, 1'b0);
      check("to_entry", editing, 1);
      repeat (249) cyc();
      check("to_blink_lit", blink_on, 1);
      cyc();
      check("to_blink_dark", blink_on, 0);
      repeat (749) cyc();
      check("to_not_yet", editing, 1);
      cyc();
      check("to_fired", editing, 0);
      check("to_fired_blink", blink_on, 0);

      // Timeout restart: key_inc on the would-be timeout edge wins
      press(1'b1, 1'b0, 1'b0);
      repeat (999) cyc();
      check("tr_pre_key_blink", blink_on, 0);
      press(1'b0, 1'b1, 1'b0);
      check("tr_key_wins", editing, 1);
      check("tr_key_inc",  edit_hour, 8);
      check("tr_key_blink", blink_on, 1);
      repeat (999) cyc();
      check("tr_not_yet", editing, 1);
      cyc();
      check("tr_fired", editing, 0);

      // Conflict: key_ok with key_inc commits the un-incremented value
      cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
      model = 2'b11;
      cyc();
      check("cf_capture", {edit_hour, edit_min, edit_sec}, {5'd10, 6'd20, 6'd30});
      expect_load(1'b1, 1'b0, 5'd10, 6'd20, 6'd30);
      press(1'b0, 1'b1, 1'b1);
      check("cf_ok_wins", time_load, 1);
      cyc();

      // Conflict: mode change alongside key_ok abandons with no strobe
      press(1'b1, 1'b0, 1'b0);
      check("cf2_entry", editing, 1);
      model = 2'b10;
      press(1'b0, 1'b0, 1'b1);
      check("cf2_abandon", editing, 0);
      check("cf2_no_strobe", {time_load, alm_load}, 0);
      cyc();

      // Reset mid-session clears at once
      model = 2'b11;
      cyc();
      check("mr_entry", editing, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_editing", editing, 0);
      check("mr_outputs", {edit_hour, edit_min, edit_sec, field_sel, blink_on, time_load, alm_load}, 0);
      model = 2'b00;
      cyc();
      rst_n = 1'b1;
      cyc();
      check("mr_idle_after", editing, 0);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/set_ctrl.md
# set_ctrl

- Controller for the digital clock's setting modes.
- Follows the 2-bit mode code from the mode selector: 00 clock, 01 alarm, 10 stopwatch, 11 set-time.
- In set-time (11) and alarm (01) modes it runs the editing session:
  - captures the current time or alarm value;
  - steps through fields and increments them with wrap;
  - on confirm, issues a one-cycle load pulse to the time-of-day counter or the alarm register.
- It sits between the debounced key pulses and the clock/alarm datapath registers.

## Interface
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- TIMEOUT_S, 10: seconds without a key press before the session is abandoned.
- BLINK_HZ, 2: blink rate of the selected field.

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- model  in  2  current mode code
- key_sel  in  1  debounced one-cycle pulse: next field
- key_inc  in  1  debounced one-cycle pulse: increment selected field
- key_ok  in  1  debounced one-cycle pulse: commit
- cur_hour / cur_min / cur_sec  in  5/6/6  running time
- alm_hour / alm_min  in  5/6  stored alarm
- edit_hour / edit_min / edit_sec  out  5/6/6  value under edit, to display and load ports
- field_sel  out  2  0 none, 1 hour, 2 min, 3 sec
- blink_on  out  1  1 when the selected field is shown
- editing  out  1  session active
- time_load  out  1  one-cycle load strobe to the time counter
- alm_load  out  1  one-cycle load strobe to the alarm register

## Operation
- States: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT.
- Target flag (TIME/ALARM) is latched at session entry.
- Session entry from IDLE:
  - Trigger: registered model_q differs from model and the new model is 11 or 01, or key_sel while model is 11 or 01.
  - Action: edit_* capture cur_* (TIME) or alm_* with edit_sec=0 (ALARM); go to EDIT_H.
- Field stepping with key_sel:
  - TIME: EDIT_H→EDIT_M→EDIT_S→EDIT_H.
  - ALARM: EDIT_H→EDIT_M→EDIT_H; EDIT_S is never entered.
- key_inc increments the selected field with wrap: hour 23→0, min/sec 59→0. Other fields are untouched.
- key_ok goes to COMMIT. COMMIT lasts one cycle, asserts time_load (TIME) or alm_load (ALARM), then returns to IDLE.
- Key priority when pulses coincide: key_ok > key_sel > key_inc. Lower-priority pulses in that cycle are dropped.
- Abandon: go to IDLE with no load strobe if either of these occurs:
  - model changes while in an EDIT_* state;
  - TIMEOUT_S·CLK_FREQ cycles pass with no key pulse.
- edit_* hold their last value in IDLE.
- field_sel is 0 in IDLE/COMMIT and 1/2/3 in EDIT_H/M/S.
- editing is 1 in EDIT_* and COMMIT.
- Blink:
  - blink_on toggles every CLK_FREQ/(2·BLINK_HZ) cycles while in EDIT_*.
  - Any key pulse forces it to 1 and restarts the blink counter.
  - Forced 0 in IDLE.
- Timeout counter clears on any key pulse and on session entry.

## Timing
- Reset values:
  - state IDLE, model_q 00;
  - edit_* 0, field_sel 0, blink_on 0, editing 0;
  - time_load 0, alm_load 0;
  - all counters 0.
- Every action takes effect on the clk edge that samples the triggering input; no combinational input-to-output paths.
- Mode entry: model changes before edge N → at edge N state=EDIT_H, edit_* loaded, editing=1.
- key_ok sampled at edge N → COMMIT and load strobe high for cycle N..N+1 → IDLE at edge N+1. edit_* are stable during the strobe.
- Mode change in the same cycle as key_ok: abandon wins; no strobe.
- Timeout fires on the edge where the counter reaches TIMEOUT_S·CLK_FREQ−1. A key pulse on that same edge wins and resets the counter.
- Reset asserted mid-session clears immediately, with no strobe.

## Structure
- Shared package clock_pkg holds:
  - mode codes (MODE_CLOCK, MODE_ALARM, MODE_STOPWATCH, MODE_SET);
  - field_sel codes;
  - the state encoding;
  - limits HOUR_MAX=23, MIN_MAX=59.
- One sub-module, tick_div, is natural. It is a parameterised cycle counter with a restart input and a terminal-count pulse. Two instances are used: the timeout counter and the blink divider.
- Field increment/wrap logic stays inline.

## Test plan
- Reset: assert rst_n=0 mid-session → all outputs 0 and state IDLE within the reset cycle; no load strobe.
- Time set:
  - Stimulus: cur=12:34:56, model 00→11.
  - Next edge: editing=1, field_sel=1, edit=12:34:56.
  - 12× key_inc → edit_hour=0.
  - key_ok → time_load high exactly 1 cycle with edit=00:34:56, then editing=0.
- Wrap and isolation: in EDIT_M with edit_min=59, one key_inc → edit_min=0 while edit_hour and edit_sec are unchanged. Same check for sec 59→0.
- Alarm:
  - Stimulus: alm=07:30, model→01.
  - Entry: edit=07:30:00.
  - key_sel, key_sel → field_sel 1→2→1 (never 3).
  - key_ok → alm_load one cycle; time_load stays 0.
- Timeout (CLK_FREQ=1000, TIMEOUT_S=1):
  - No keys for 1000 cycles → IDLE, no strobe.
  - Repeat with key_inc at cycle 999 → still editing, and timeout occurs 1000 cycles after that key.
- Conflicts:
  - key_ok and key_inc in the same cycle → committed value is the un-incremented one.
  - model 11→10 in the same cycle as key_ok → IDLE with no strobe.
